// File: rtl/morph_filter_stats_if.sv
// Pixel-stream and frame-statistics bundle for the morphology/statistics stage.
// master = video source / consumer side, slave = the filter itself.
interface morph_filter_stats_if;
    logic [10:0] hpos;
    logic [10:0] vpos;
    logic        in_pix;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_pix;
    logic [10:0] out_hpos;
    logic [10:0] out_vpos;
    logic        stats_valid;
    logic [18:0] fg_count;
    logic [10:0] bbox_xmin;
    logic [10:0] bbox_xmax;
    logic [10:0] bbox_ymin;
    logic [10:0] bbox_ymax;

    modport master (
        output hpos, vpos, in_pix, mode,
        input  out_valid, out_pix, out_hpos, out_vpos,
        input  stats_valid, fg_count, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax
    );

    modport slave (
        input  hpos, vpos, in_pix, mode,
        output out_valid, out_pix, out_hpos, out_vpos,
        output stats_valid, fg_count, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax
    );
endinterface

// File: rtl/morph_filter_stats.sv
// Streaming binary erode/dilate/bypass over a WIN x WIN window, with per-frame
// foreground pixel count and bounding box of the filtered output.
module morph_filter_stats #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int WIN   = 5
) (
    input logic app_clk,
    input logic app_rst_n,
    morph_filter_stats_if.slave px
);
    localparam int R  = WIN / 2;
    localparam int AW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam logic [10:0] H_ACT  = 11'(H_RES);
    localparam logic [10:0] V_ACT  = 11'(V_RES);
    localparam logic [10:0] H_FEED = 11'(H_RES + R);
    localparam logic [10:0] V_FEED = 11'(V_RES + R);
    localparam logic [10:0] RR     = 11'(R);
    localparam logic [10:0] X_LAST = 11'(H_RES - 1);
    localparam logic [10:0] Y_LAST = 11'(V_RES - 1);

    typedef enum logic [1:0] {
        M_BYP    = 2'b00,
        M_ERODE  = 2'b01,
        M_DILATE = 2'b10,
        M_RSVD   = 2'b11
    } mode_e;

    typedef struct packed {
        logic [18:0] cnt;
        logic [10:0] xmin;
        logic [10:0] xmax;
        logic [10:0] ymin;
        logic [10:0] ymax;
    } stats_t;

    localparam stats_t STATS_EMPTY = '{cnt: '0, xmin: 11'h7ff, xmax: '0, ymin: 11'h7ff, ymax: '0};

    logic                      frame_start, active, feed, pad;
    logic [AW-1:0]             lb_idx;
    mode_e                     cur_mode, mode_q, mode_d;
    mode_e                     win_mode_q, win_mode_d;
    logic [WIN-1:0]            col;
    logic [WIN-2:0][H_RES-1:0] lb_q, lb_d;
    logic [WIN-1:0][WIN-1:0]   win_q, win_d;
    logic                      cen_vld_q, cen_vld_d;
    logic [10:0]               cen_x_q, cen_x_d, cen_y_q, cen_y_d;
    logic                      out_valid_q, out_valid_d, out_pix_q, out_pix_d;
    logic [10:0]               out_hpos_q, out_hpos_d, out_vpos_q, out_vpos_d;
    logic                      armed_q, armed_d;
    logic                      stats_valid_q, stats_valid_d;
    stats_t                    acc_q, acc_d, pub_q, pub_d;

    always_comb begin
        frame_start = (px.hpos == '0) && (px.vpos == '0);
        active      = (px.hpos < H_ACT) && (px.vpos < V_ACT);
        feed        = (px.hpos < H_FEED) && (px.vpos < V_FEED);
        // The mode captured at frame start must already govern padding of that first pixel.
        cur_mode    = frame_start ? mode_e'(px.mode) : mode_q;
        mode_d      = cur_mode;
        pad         = (cur_mode == M_ERODE);
        lb_idx      = px.hpos[AW-1:0];
        col         = {WIN{pad}};
        lb_d        = lb_q;

        // col[WIN-1] is line vpos, col[WIN-1-k] is line vpos-k; lines above the frame pad.
        if (px.hpos < H_ACT) begin
            col[WIN-1] = active ? px.in_pix : pad;
            for (int k = 1; k < WIN; k++) begin
                if (px.vpos >= 11'(k)) col[WIN-1-k] = lb_q[k-1][lb_idx];
            end
            if (feed) begin
                lb_d[0][lb_idx] = col[WIN-1];
                for (int k = 1; k < WIN - 1; k++) lb_d[k][lb_idx] = lb_q[k-1][lb_idx];
            end
        end

        // The trailing R padding columns of each line become the left margin of the next.
        win_d      = win_q;
        win_mode_d = win_mode_q;
        if (feed) begin
            win_d      = {col, win_q[WIN-1:1]};
            win_mode_d = cur_mode;
        end
        cen_vld_d = feed && (px.hpos >= RR) && (px.vpos >= RR);
        cen_x_d   = px.hpos - RR;
        cen_y_d   = px.vpos - RR;

        out_valid_d = cen_vld_q;
        out_hpos_d  = cen_x_q;
        out_vpos_d  = cen_y_q;
        out_pix_d   = win_q[R][R];
        case (win_mode_q)
            M_ERODE:  out_pix_d = &win_q;
            M_DILATE: out_pix_d = |win_q;
            default:  out_pix_d = win_q[R][R];
        endcase

        armed_d       = armed_q | frame_start;
        acc_d         = acc_q;
        pub_d         = pub_q;
        stats_valid_d = 1'b0;
        if (armed_q && out_valid_q) begin
            if (out_pix_q) begin
                acc_d.cnt = acc_q.cnt + 19'd1;
                if (out_hpos_q < acc_q.xmin) acc_d.xmin = out_hpos_q;
                if (out_hpos_q > acc_q.xmax) acc_d.xmax = out_hpos_q;
                if (out_vpos_q < acc_q.ymin) acc_d.ymin = out_vpos_q;
                if (out_vpos_q > acc_q.ymax) acc_d.ymax = out_vpos_q;
            end
            if (out_hpos_q == X_LAST && out_vpos_q == Y_LAST) begin
                pub_d         = acc_d;
                stats_valid_d = 1'b1;
                acc_d         = STATS_EMPTY;
            end
        end
    end

    // Line buffer contents are deliberately left unreset; rows outside the frame are padded.
    always_ff @(posedge app_clk) begin
        lb_q <= lb_d;
    end

    always_ff @(posedge app_clk or negedge app_rst_n) begin
        if (!app_rst_n) begin
            mode_q        <= M_BYP;
            win_mode_q    <= M_BYP;
            win_q         <= '0;
            cen_vld_q     <= 1'b0;
            cen_x_q       <= '0;
            cen_y_q       <= '0;
            out_valid_q   <= 1'b0;
            out_pix_q     <= 1'b0;
            out_hpos_q    <= '0;
            out_vpos_q    <= '0;
            armed_q       <= 1'b0;
            stats_valid_q <= 1'b0;
            acc_q         <= STATS_EMPTY;
            pub_q         <= STATS_EMPTY;
        end else begin
            mode_q        <= mode_d;
            win_mode_q    <= win_mode_d;
            win_q         <= win_d;
            cen_vld_q     <= cen_vld_d;
            cen_x_q       <= cen_x_d;
            cen_y_q       <= cen_y_d;
            out_valid_q   <= out_valid_d;
            out_pix_q     <= out_pix_d;
            out_hpos_q    <= out_hpos_d;
            out_vpos_q    <= out_vpos_d;
            armed_q       <= armed_d;
            stats_valid_q <= stats_valid_d;
            acc_q         <= acc_d;
            pub_q         <= pub_d;
        end
    end

    assign px.out_valid   = out_valid_q;
    assign px.out_pix     = out_pix_q;
    assign px.out_hpos    = out_hpos_q;
    assign px.out_vpos    = out_vpos_q;
    assign px.stats_valid = stats_valid_q;
    assign px.fg_count    = pub_q.cnt;
    assign px.bbox_xmin   = pub_q.xmin;
    assign px.bbox_xmax   = pub_q.xmax;
    assign px.bbox_ymin   = pub_q.ymin;
    assign px.bbox_ymax   = pub_q.ymax;
endmodule

// File: tb/tb_morph_filter_stats.sv
// Directed bench for morph_filter_stats on a small 12x10 raster (WIN=5),
// checking the filtered stream against a window model and the frame statistics.
module tb_morph_filter_stats;
    localparam int H  = 12;
    localparam int V  = 10;
    localparam int WIN = 5;
    localparam int R  = WIN / 2;
    localparam int HT = 18;
    localparam int VT = 14;
    localparam int PULSE_S = (V + 1) * HT + H + 4;
    localparam logic [62:0] ST_EMPTY = {19'd0, 11'd2047, 11'd0, 11'd2047, 11'd0};
    localparam logic [87:0] RST_VALS = {1'b0, 1'b0, 11'd0, 11'd0, 1'b0, ST_EMPTY};

    logic app_clk = 1'b0;
    logic app_rst_n = 1'b0;
    morph_filter_stats_if io();

    morph_filter_stats #(.H_RES(H), .V_RES(V), .WIN(WIN)) dut (
        .app_clk  (app_clk),
        .app_rst_n(app_rst_n),
        .px       (io)
    );

    always #5 app_clk = ~app_clk;

    int checks = 0;
    int errors = 0;
    logic img [V][H];
    int h1 = 100, v1 = 100, h2 = 100, v2 = 100;
    int f_pulses, f_pulse_s, f_nbad;
    string f_bad;
    logic [62:0] f_stats;
    logic [87:0] r_snap;

    function automatic logic [62:0] cur_stats();
        return {io.fg_count, io.bbox_xmin, io.bbox_xmax, io.bbox_ymin, io.bbox_ymax};
    endfunction

    function automatic logic [87:0] snap();
        return {io.out_valid, io.out_pix, io.out_hpos, io.out_vpos, io.stats_valid, cur_stats()};
    endfunction

    function automatic logic exp_pix(int x, int y, logic [1:0] m);
        logic a = 1'b1, o = 1'b0, b, pad;
        pad = (m == 2'b01);
        for (int dy = -R; dy <= R; dy++)
            for (int dx = -R; dx <= R; dx++) begin
                b = (x + dx >= 0 && x + dx < H && y + dy >= 0 && y + dy < V) ? img[y+dy][x+dx] : pad;
                a = a & b;
                o = o | b;
            end
        case (m)
            2'b01:   return a;
            2'b10:   return o;
            default: return img[y][x];
        endcase
    endfunction

    function automatic logic [62:0] model_stats(logic [1:0] m);
        int cnt = 0, xmin = 2047, xmax = 0, ymin = 2047, ymax = 0;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                if (exp_pix(x, y, m)) begin
                    cnt++;
                    if (x < xmin) xmin = x;
                    if (x > xmax) xmax = x;
                    if (y < ymin) ymin = y;
                    if (y > ymax) ymax = y;
                end
        return {19'(cnt), 11'(xmin), 11'(xmax), 11'(ymin), 11'(ymax)};
    endfunction

    task automatic fill_img(input logic val);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) img[y][x] = val;
    endtask

    // Drives one full raster frame (with blanking) and records what the DUT produced.
    task automatic run_frame(input logic [1:0] m, input int chg_row, input logic [1:0] m2,
                             input int rst_row);
        f_pulses = 0; f_pulse_s = -1; f_nbad = 0; f_bad = "none"; f_stats = '0; r_snap = '1;
        io.mode = m;
        for (int v = 0; v < VT; v++)
            for (int h = 0; h < HT; h++) begin
                int s = v * HT + h;
                bit ev;
                logic ep;
                bit bad;
                @(negedge app_clk);
                if (!app_rst_n) r_snap = snap();
                if (io.stats_valid) begin
                    f_pulses++;
                    f_pulse_s = s;
                    f_stats = cur_stats();
                end
                if (rst_row < 0) begin
                    ev = (h2 >= R && h2 < H + R && v2 >= R && v2 < V + R);
                    bad = (io.out_valid !== ev);
                    if (!bad && ev) begin
                        ep = exp_pix(h2 - R, v2 - R, m);
                        bad = ({io.out_pix, io.out_hpos, io.out_vpos} !== {ep, 11'(h2 - R), 11'(v2 - R)});
                    end
                    if (bad) begin
                        f_nbad++;
                        if (f_nbad == 1)
                            f_bad = $sformatf("in(%0d,%0d) got valid=%0b pix=%0b x=%0d y=%0d",
                                              h2, v2, io.out_valid, io.out_pix, io.out_hpos, io.out_vpos);
                    end
                end
                h2 = h1; v2 = v1; h1 = h; v1 = v;
                if (v == chg_row && h == 0) io.mode = m2;
                io.hpos = 11'(h);
                io.vpos = 11'(v);
                io.in_pix = (h < H && v < V) ? img[v][h] : 1'b1;
                app_rst_n = !(v == rst_row && h == 3);
            end
    endtask

    task automatic check_frame(input string name, input logic [62:0] exp_st);
        checks++;
        if (f_nbad !== 0) begin
            errors++;
            $display("FAIL %s pixel_stream: %0d bad pixels, first %s", name, f_nbad, f_bad);
        end
        checks++;
        if (f_pulses != 1 || f_pulse_s != PULSE_S) begin
            errors++;
            $display("FAIL %s stats_pulse: got %0d pulses at step %0d, required 1 at step %0d",
                     name, f_pulses, f_pulse_s, PULSE_S);
        end
        checks++;
        if (f_stats !== exp_st) begin
            errors++;
            $display("FAIL %s stats: got cnt=%0d x=%0d..%0d y=%0d..%0d required cnt=%0d x=%0d..%0d y=%0d..%0d",
                     name, f_stats[62:44], f_stats[43:33], f_stats[32:22], f_stats[21:11], f_stats[10:0],
                     exp_st[62:44], exp_st[43:33], exp_st[32:22], exp_st[21:11], exp_st[10:0]);
        end
    endtask

    task automatic test_reset();
        app_rst_n = 1'b0;
        io.hpos = 11'(HT - 1); io.vpos = 11'(VT - 1); io.in_pix = 1'b1; io.mode = 2'b01;
        repeat (3) @(negedge app_clk);
        checks++;
        if (snap() !== RST_VALS) begin
            errors++;
            $display("FAIL reset_values: got %h required %h", snap(), RST_VALS);
        end
        app_rst_n = 1'b1;
        repeat (4) @(negedge app_clk);
        checks++;
        if ({io.out_valid, io.stats_valid} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: got valid=%0b stats_valid=%0b required 0 0",
                     io.out_valid, io.stats_valid);
        end
    endtask

    task automatic test_bypass_random();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) img[y][x] = 1'($urandom_range(0, 1));
        run_frame(2'b00, -1, 2'b00, -1);
        check_frame("bypass_rand0", model_stats(2'b00));
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) img[y][x] = 1'($urandom_range(0, 1));
        run_frame(2'b11, -1, 2'b00, -1);
        check_frame("bypass_mode11", model_stats(2'b00));
    endtask

    task automatic test_erode_block();
        fill_img(1'b0);
        for (int y = 2; y <= 6; y++)
            for (int x = 3; x <= 7; x++) img[y][x] = 1'b1;
        run_frame(2'b01, -1, 2'b00, -1);
        check_frame("erode_block", {19'd1, 11'd5, 11'd5, 11'd4, 11'd4});
    endtask

    task automatic test_dilate_corner();
        fill_img(1'b0);
        img[0][0] = 1'b1;
        run_frame(2'b10, -1, 2'b00, -1);
        check_frame("dilate_corner", {19'd9, 11'd0, 11'd2, 11'd0, 11'd2});
    endtask

    task automatic test_erode_ones();
        fill_img(1'b1);
        run_frame(2'b01, -1, 2'b00, -1);
        check_frame("erode_ones", {19'd120, 11'd0, 11'd11, 11'd0, 11'd9});
    endtask

    task automatic test_reset_mid_frame();
        fill_img(1'b1);
        run_frame(2'b01, -1, 2'b00, 5);
        checks++;
        if (r_snap !== RST_VALS) begin
            errors++;
            $display("FAIL midframe_reset_values: got %h required %h", r_snap, RST_VALS);
        end
        checks++;
        if (f_pulses != 0) begin
            errors++;
            $display("FAIL midframe_no_pulse: got %0d pulses required 0", f_pulses);
        end
        fill_img(1'b0);
        img[0][0] = 1'b1;
        run_frame(2'b10, 4, 2'b01, -1);
        check_frame("after_reset_mode_toggle", {19'd9, 11'd0, 11'd2, 11'd0, 11'd2});
    endtask

    task automatic test_zero_frames();
        fill_img(1'b0);
        for (int m = 0; m < 4; m++) begin
            run_frame(2'(m), -1, 2'b00, -1);
            check_frame($sformatf("zero_mode%0d", m), ST_EMPTY);
        end
    endtask

    initial begin
        test_reset();
        test_bypass_random();
        test_erode_block();
        test_dilate_corner();
        test_erode_ones();
        test_reset_mid_frame();
        test_zero_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
